riscv_top: RTL and testbench



---
 rtl/riscv_top_pkg.sv | 55 +++++
 rtl/riscv_top_if.sv | 24 ++
 rtl/riscv_top_regfile.sv | 37 +++
 rtl/riscv_top.sv | 160 ++++++++++++++++
 tb/tb_riscv_top.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_top_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_top_pkg
// Purpose : Shared definitions for the single-cycle RV32I-subset core:
//           opcode and ALU-operation enums, funct3 constants, the output-port
//           store address and the NOP encoding used to fill instruction memory.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package riscv_top_pkg;

  localparam logic [31:0] IO_OUT_ADDR = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  // Major opcodes recognised by the core; anything else retires as a NOP.
  typedef enum logic [6:0] {
    OPC_OP     = 7'h33,
    OPC_OP_IMM = 7'h13,
    OPC_LUI    = 7'h37,
    OPC_AUIPC  = 7'h17,
    OPC_JAL    = 7'h6F,
    OPC_JALR   = 7'h67,
    OPC_BRANCH = 7'h63,
    OPC_STORE  = 7'h23
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  // ALU funct3 values (register and immediate forms)
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3 values
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Store / jump funct3 values
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

endpackage
`default_nettype wire

// File: rtl/riscv_top_if.sv
`default_nettype none
// ============================================================================
// Module  : riscv_top_if
// Purpose : Bundles the flash-programming port and the memory-mapped output
//           port of the core.
// Ports   : flash_addr  byte address of instruction word to write
//           flash_data  instruction word to write
//           flash_en    write strobe, one write per cycle while high
//           outport     registered output port
//           master = programmer/observer side, slave = core side
// Rev     : 1.0  initial release
// ============================================================================
interface riscv_top_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] flash_addr;
  logic [WIDTH-1:0] flash_data;
  logic             flash_en;
  logic [WIDTH-1:0] outport;

  modport master (output flash_addr, flash_data, flash_en, input outport);
  modport slave  (input  flash_addr, flash_data, flash_en, output outport);
endinterface
`default_nettype wire

// File: rtl/riscv_top_regfile.sv
`default_nettype none
// ============================================================================
// Module  : riscv_top_regfile
// Purpose : 32 x WIDTH integer register file, x0 hard-wired to zero.
// Ports   : clk, rst               clock, synchronous active-high clear
//           i_rs1_addr/o_rs1_data  asynchronous read port 1
//           i_rs2_addr/o_rs2_data  asynchronous read port 2
//           i_we/i_rd_addr/i_rd_data synchronous write port
// Rev     : 1.0  initial release
// ============================================================================
module riscv_top_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_rs1_addr,
  output logic [WIDTH-1:0] o_rs1_data,
  input  logic [4:0]       i_rs2_addr,
  output logic [WIDTH-1:0] o_rs2_data,
  input  logic             i_we,
  input  logic [4:0]       i_rd_addr,
  input  logic [WIDTH-1:0] i_rd_data
);
  logic [WIDTH-1:0] r_regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_rd_addr != 5'd0)) begin
      r_regs[i_rd_addr] <= i_rd_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];
endmodule
`default_nettype wire

// File: rtl/riscv_top.sv
`default_nettype none
// ============================================================================
// Module  : riscv_top
// Purpose : Single-cycle RV32I-subset core with flash-loadable 512-word
//           instruction memory and one memory-mapped output port. Decode,
//           immediate generation, ALU, branch compare and instruction memory
//           live here; the register file is a sub-module.
// Ports   : clk   rising-edge clock
//           rst   synchronous active-high reset (pc, registers, outport)
//           bus   riscv_top_if slave: flash write port + outport
// Rev     : 1.0  initial release
// ============================================================================
module riscv_top
  import riscv_top_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  riscv_top_if.slave bus
);
  // Contents survive reset; only flash writes change them.
  logic [31:0]      r_imem [512] = '{default: NOP};
  logic [WIDTH-1:0] r_pc;

  logic [31:0]      w_instr;
  logic [6:0]       w_opcode, w_funct7;
  logic [4:0]       w_rd, w_rs1, w_rs2;
  logic [2:0]       w_funct3;
  logic [WIDTH-1:0] w_rs1_data, w_rs2_data;
  logic [WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [WIDTH-1:0] w_pc_plus4, w_alu_b, w_alu_res, w_rd_data, w_next_pc;
  logic [4:0]       w_shamt;
  alu_op_e          w_alu_op;
  logic             w_rd_we, w_io_store, w_br_taken, w_r_ok, w_i_ok;
  logic             w_unused_flash;

  // Flash write: word index only, byte-lane and upper address bits ignored.
  always_ff @(posedge clk) begin
    if (bus.flash_en) r_imem[bus.flash_addr[10:2]] <= bus.flash_data;
  end
  assign w_unused_flash = ^{bus.flash_addr[31:11], bus.flash_addr[1:0]};

  // Fetch reads the pre-edge word, so a same-cycle flash write is seen next cycle.
  assign w_instr  = r_imem[r_pc[10:2]];
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_funct7 = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'h000};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  assign w_pc_plus4 = r_pc + 32'd4;

  riscv_top_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_rs1_addr (w_rs1),
    .o_rs1_data (w_rs1_data),
    .i_rs2_addr (w_rs2),
    .o_rs2_data (w_rs2_data),
    .i_we       (w_rd_we),
    .i_rd_addr  (w_rd),
    .i_rd_data  (w_rd_data)
  );

  always_comb begin
    w_alu_op   = ALU_ADD;
    w_alu_res  = '0;
    w_rd_we    = 1'b0;
    w_rd_data  = '0;
    w_next_pc  = w_pc_plus4;
    w_io_store = 1'b0;
    w_br_taken = 1'b0;

    // funct7 legality: only ADD/SUB and SRL/SRA may carry bit 30.
    w_r_ok = (w_funct7 == 7'h00) ||
             ((w_funct7 == 7'h20) && ((w_funct3 == F3_ADD_SUB) || (w_funct3 == F3_SRL_SRA)));
    w_i_ok = (w_funct3 == F3_SLL)     ? (w_funct7 == 7'h00) :
             (w_funct3 == F3_SRL_SRA) ? ((w_funct7 == 7'h00) || (w_funct7 == 7'h20)) : 1'b1;

    w_alu_b = (w_opcode == OPC_OP) ? w_rs2_data : w_imm_i;
    w_shamt = w_alu_b[4:0];

    case (w_funct3)
      F3_ADD_SUB: w_alu_op = ((w_opcode == OPC_OP) && w_funct7[5]) ? ALU_SUB : ALU_ADD;
      F3_SLL:     w_alu_op = ALU_SLL;
      F3_SLT:     w_alu_op = ALU_SLT;
      F3_SLTU:    w_alu_op = ALU_SLTU;
      F3_XOR:     w_alu_op = ALU_XOR;
      F3_SRL_SRA: w_alu_op = w_funct7[5] ? ALU_SRA : ALU_SRL;
      F3_OR:      w_alu_op = ALU_OR;
      default:    w_alu_op = ALU_AND;
    endcase

    case (w_alu_op)
      ALU_ADD:  w_alu_res = w_rs1_data + w_alu_b;
      ALU_SUB:  w_alu_res = w_rs1_data - w_alu_b;
      ALU_XOR:  w_alu_res = w_rs1_data ^ w_alu_b;
      ALU_OR:   w_alu_res = w_rs1_data | w_alu_b;
      ALU_AND:  w_alu_res = w_rs1_data & w_alu_b;
      ALU_SLL:  w_alu_res = w_rs1_data << w_shamt;
      ALU_SRL:  w_alu_res = w_rs1_data >> w_shamt;
      ALU_SRA:  w_alu_res = $signed(w_rs1_data) >>> w_shamt;
      ALU_SLT:  w_alu_res = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
      ALU_SLTU: w_alu_res = {31'd0, w_rs1_data < w_alu_b};
      default:  w_alu_res = '0;
    endcase

    case (w_funct3)
      F3_BEQ:  w_br_taken = (w_rs1_data == w_rs2_data);
      F3_BNE:  w_br_taken = (w_rs1_data != w_rs2_data);
      F3_BLT:  w_br_taken = ($signed(w_rs1_data) <  $signed(w_rs2_data));
      F3_BGE:  w_br_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
      F3_BLTU: w_br_taken = (w_rs1_data <  w_rs2_data);
      F3_BGEU: w_br_taken = (w_rs1_data >= w_rs2_data);
      default: w_br_taken = 1'b0;
    endcase

    // Illegal sub-encodings fall through with all writes off: NOP behaviour.
    case (w_opcode)
      OPC_OP:     begin w_rd_we = w_r_ok; w_rd_data = w_alu_res; end
      OPC_OP_IMM: begin w_rd_we = w_i_ok; w_rd_data = w_alu_res; end
      OPC_LUI:    begin w_rd_we = 1'b1;   w_rd_data = w_imm_u; end
      OPC_AUIPC:  begin w_rd_we = 1'b1;   w_rd_data = r_pc + w_imm_u; end
      OPC_JAL: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      OPC_JALR: begin
        if (w_funct3 == F3_JALR) begin
          w_rd_we   = 1'b1;
          w_rd_data = w_pc_plus4;
          w_next_pc = (w_rs1_data + w_imm_i) & ~32'd1;
        end
      end
      OPC_BRANCH: if (w_br_taken) w_next_pc = r_pc + w_imm_b;
      OPC_STORE:  w_io_store = (w_funct3 == F3_SW) && ((w_rs1_data + w_imm_s) == IO_OUT_ADDR);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      bus.outport <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_io_store) bus.outport <= w_rs2_data;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_riscv_top.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_top
// Purpose : Self-checking bench for riscv_top: directed programs from the
//           block description plus random programs compared cycle by cycle
//           against an instruction-level reference model.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_riscv_top;
  localparam logic [6:0] OPC_OP = 7'h33, OPC_IMM = 7'h13, OPC_LUI = 7'h37, OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL = 7'h6F, OPC_JALR = 7'h67, OPC_BR = 7'h63, OPC_ST = 7'h23;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_top_if #(.WIDTH(32)) bus ();
  riscv_top #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_mem  [512];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_out;
  logic [4:0]  m_rd;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] xr(input int i);
    return dut.u_regfile.r_regs[i];
  endfunction

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_ST};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BR};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc  = 32'd0;
    m_out = 32'd0;
    m_rd  = 5'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  task automatic model_wr(input logic [4:0] rd, input logic [31:0] v);
    m_rd = rd;
    if (rd != 5'd0) m_regs[rd] = v;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, res, nxt, iI, iS, iB, iU, iJ, t;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          ok, is_r, take;
    ins = m_mem[m_pc[10:2]];
    rd  = ins[11:7];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    iI  = {{20{ins[31]}}, ins[31:20]};
    iS  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    iB  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iU  = {ins[31:12], 12'h000};
    iJ  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 32'd4;
    m_rd = 5'd0;
    case (ins[6:0])
      OPC_OP, OPC_IMM: begin
        is_r = (ins[6:0] == OPC_OP);
        if (!is_r) b = iI;
        if (is_r)         ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (f3 == 1) ok = (f7 == 7'h00);
        else if (f3 == 5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else              ok = 1'b1;
        if (ok) begin
          case (f3)
            3'd0: res = (is_r && f7 == 7'h20) ? a - b : a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: begin
              if (f7 == 7'h20) res = $signed(a) >>> b[4:0];
              else             res = a >> b[4:0];
            end
            3'd6: res = a | b;
            default: res = a & b;
          endcase
          model_wr(rd, res);
        end
      end
      OPC_LUI:   model_wr(rd, iU);
      OPC_AUIPC: model_wr(rd, m_pc + iU);
      OPC_JAL: begin
        model_wr(rd, m_pc + 32'd4);
        nxt = m_pc + iJ;
      end
      OPC_JALR: if (f3 == 3'd0) begin
        t = (a + iI) & 32'hFFFF_FFFE;
        model_wr(rd, m_pc + 32'd4);
        nxt = t;
      end
      OPC_BR: begin
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) <  $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a <  b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) nxt = m_pc + iB;
      end
      OPC_ST: if (f3 == 3'd2 && (a + iS) == 32'hFFFF_FFFC) m_out = b;
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // One clock: advance model, then compare pc, outport and last-written register.
  task automatic tick(input bit chk);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    if (bus.flash_en) m_mem[bus.flash_addr[10:2]] = bus.flash_data;
    #1;
    if (chk) begin
      check_eq("pc", dut.r_pc, m_pc);
      check_eq("outport", bus.outport, m_out);
      check_eq("rd_value", xr(int'(m_rd)), m_regs[m_rd]);
    end
    @(negedge clk);
  endtask

  task automatic flash_word(input logic [31:0] addr, input logic [31:0] data);
    bus.flash_addr = addr;
    bus.flash_data = data;
    bus.flash_en   = 1'b1;
    tick(1'b1);
    bus.flash_en   = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] i12;
    int          o;
    rd  = 5'($urandom_range(0, 15));
    rs1 = 5'($urandom_range(0, 15));
    rs2 = 5'($urandom_range(0, 15));
    f3  = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 11))
      0, 1: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_r(f7, rs2, rs1, f3, rd, OPC_OP);
      end
      2, 3: begin
        i12 = 12'($urandom());
        if (f3 == 3'd1)      i12[11:5] = 7'h00;
        else if (f3 == 3'd5) i12[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_i(i12, rs1, f3, rd, OPC_IMM);
      end
      4: return enc_u(20'($urandom()), rd, OPC_LUI);
      5: return enc_u(20'($urandom()), rd, OPC_AUIPC);
      6: begin
        o = $urandom_range(1, 8) * 4;
        if ($urandom_range(0, 1) == 1) o = -o;
        return enc_j(21'(o), rd);
      end
      7: return enc_i(12'($urandom_range(0, 255)), rs1, 3'd0, rd, OPC_JALR);
      8, 9: begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 >= 3'd2) f3 = f3 + 3'd2;
        o = $urandom_range(1, 8) * 4;
        if ($urandom_range(0, 1) == 1) o = -o;
        return enc_b(13'(o), rs2, rs1, f3);
      end
      10: begin
        if ($urandom_range(0, 1) == 1) return enc_s(12'hFFC, rs2, 5'd0);
        return enc_s(12'($urandom()), rs2, rs1);
      end
      default: begin
        case ($urandom_range(0, 3))
          0: return 32'hFFFF_FFFF;
          1: return enc_i(12'($urandom()), rs1, 3'd2, rd, 7'h03);
          2: return 32'h0000_000F;
          default: return 32'h0000_0073;
        endcase
      end
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) m_mem[i] = 32'h0000_0013;
    model_reset();
    bus.flash_addr = '0;
    bus.flash_data = '0;
    bus.flash_en   = 1'b0;
    @(negedge clk);

    // ---- reset state ----
    tick(1'b1);
    tick(1'b1);
    check_eq("rst_pc", dut.r_pc, 32'd0);
    check_eq("rst_outport", bus.outport, 32'd0);
    check_eq("rst_x12", xr(12), 32'd0);

    // ---- counter with JAL (flashed while reset held 3 cycles) ----
    flash_word(32'd0, 32'h00c64633);
    flash_word(32'd4, 32'h00160613);
    flash_word(32'd8, 32'hffdff06f);
    rst = 1'b0;
    tick(1'b1); check_eq("cnt_pc1", dut.r_pc, 32'd4);
    tick(1'b1); check_eq("cnt_pc2", dut.r_pc, 32'd8); check_eq("cnt_x12_2", xr(12), 32'd1);
    tick(1'b1); check_eq("cnt_pc3", dut.r_pc, 32'd4);
    repeat (77) tick(1'b1);
    check_eq("cnt_x12_80", xr(12), 32'd40);

    // ---- JALR wrap through 0xFFFF_FFFC ----
    rst = 1'b1;
    flash_word(32'hABCD_E00B, 32'hffc00067);
    tick(1'b1); tick(1'b1);
    rst = 1'b0;
    tick(1'b1); check_eq("jalr_pc1", dut.r_pc, 32'd4);
    tick(1'b1); check_eq("jalr_pc2", dut.r_pc, 32'd8);
    tick(1'b1); check_eq("jalr_pc3", dut.r_pc, 32'hFFFF_FFFC);
    tick(1'b1); check_eq("jalr_pc4", dut.r_pc, 32'd0);
    tick(1'b1); check_eq("jalr_x12_0", xr(12), 32'd0);
    tick(1'b1); check_eq("jalr_x12_1", xr(12), 32'd1);

    // ---- output store, ignored store, then counter; reset mid-run ----
    rst = 1'b1;
    flash_word(32'd0,  enc_i(12'h055, 5'd0, 3'd0, 5'd5, OPC_IMM));
    flash_word(32'd4,  32'hFE502E23);
    flash_word(32'd8,  enc_i(12'h066, 5'd0, 3'd0, 5'd5, OPC_IMM));
    flash_word(32'd12, enc_s(12'h000, 5'd5, 5'd0));
    flash_word(32'd16, 32'h00c64633);
    flash_word(32'd20, 32'h00160613);
    flash_word(32'd24, 32'hffdff06f);
    rst = 1'b0;
    tick(1'b1); check_eq("st_out1", bus.outport, 32'd0);
    tick(1'b1); check_eq("st_out2", bus.outport, 32'h55);
    tick(1'b1); tick(1'b1); check_eq("st_addr0_out", bus.outport, 32'h55);
    repeat (20) tick(1'b1);
    rst = 1'b1;
    tick(1'b1);
    check_eq("mid_rst_pc", dut.r_pc, 32'd0);
    check_eq("mid_rst_x12", xr(12), 32'd0);
    check_eq("mid_rst_out", bus.outport, 32'd0);
    rst = 1'b0;
    tick(1'b1); tick(1'b1);
    check_eq("restart_out", bus.outport, 32'h55);

    // ---- ALU / branch / x0 / unsupported ----
    rst = 1'b1;
    flash_word(32'd0,  enc_i(12'd3, 5'd0, 3'd0, 5'd1, OPC_IMM));
    flash_word(32'd4,  enc_i(12'd5, 5'd0, 3'd0, 5'd2, OPC_IMM));
    flash_word(32'd8,  enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP));
    flash_word(32'd12, enc_u(20'h80000, 5'd4, OPC_LUI));
    flash_word(32'd16, enc_i(12'd4, 5'd0, 3'd0, 5'd6, OPC_IMM));
    flash_word(32'd20, enc_r(7'h20, 5'd6, 5'd4, 3'd5, 5'd7, OPC_OP));
    flash_word(32'd24, enc_i(12'd1, 5'd0, 3'd0, 5'd8, OPC_IMM));
    flash_word(32'd28, enc_i(12'hFFF, 5'd0, 3'd0, 5'd9, OPC_IMM));
    flash_word(32'd32, enc_r(7'h00, 5'd9, 5'd8, 3'd3, 5'd10, OPC_OP));
    flash_word(32'd36, enc_b(13'd8, 5'd8, 5'd9, 3'd4));
    flash_word(32'd40, enc_i(12'h077, 5'd0, 3'd0, 5'd11, OPC_IMM));
    flash_word(32'd44, enc_b(13'd8, 5'd8, 5'd9, 3'd6));
    flash_word(32'd48, enc_i(12'h022, 5'd0, 3'd0, 5'd13, OPC_IMM));
    flash_word(32'd52, enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPC_IMM));
    flash_word(32'd56, 32'h00002703);
    flash_word(32'd60, 32'hFFFF_FFFF);
    rst = 1'b0;
    repeat (13) tick(1'b1);
    check_eq("sub_3_5", xr(3), 32'hFFFF_FFFE);
    check_eq("sra_8000_4", xr(7), 32'hF800_0000);
    check_eq("sltu_1_ffff", xr(10), 32'd1);
    check_eq("blt_taken_skip", xr(11), 32'd0);
    check_eq("bltu_not_taken", xr(13), 32'h22);
    check_eq("x0_write_ignored", xr(0), 32'd0);
    check_eq("pc_before_lw", dut.r_pc, 32'd56);
    tick(1'b1);
    check_eq("lw_pc", dut.r_pc, 32'd60);
    check_eq("lw_no_write", xr(14), 32'd0);
    tick(1'b1);
    check_eq("ones_pc", dut.r_pc, 32'd64);
    check_eq("ones_out", bus.outport, 32'd0);

    // ---- random programs, mid-run flash writes and resets ----
    for (int p = 0; p < 8; p++) begin
      rst = 1'b1;
      for (int k = 0; k < 32; k++)
        flash_word(($urandom() & 32'hFFFF_F803) | (k << 2), rand_instr());
      rst = 1'b0;
      for (int c = 0; c < 300; c++) begin
        rst = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 15) == 0) begin
          bus.flash_addr = $urandom();
          bus.flash_data = rand_instr();
          bus.flash_en   = 1'b1;
        end
        tick(1'b1);
        bus.flash_en = 1'b0;
      end
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
